// File: rtl/dsp_gather_pkg.sv
// Shared types and sizing helpers for the DSP lane gatherer.
// The gatherer packs scalar operand pairs into lane vectors for the SIMD adders/subtractors.
package dsp_gather_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } gather_state_t;

    // Widest packed operand the downstream DSP adders accept.
    localparam int DSP_DATA_WIDTH = 48;

    // Number of lanes of a given width that fit in one DSP operand.
    function automatic int max_lanes(input int width);
        return DSP_DATA_WIDTH / width;
    endfunction

endpackage

// File: rtl/dsp_gather_timer.sv
// Idle counter for the lane gatherer. Compiled only when GATHER_TIMEOUT_EN is defined.
// Counts consecutive idle cycles while 'run' is high and clears as soon as 'run' drops.
// 'expired' flags the cycle in which the count has reached TIMEOUT-1.
`ifdef GATHER_TIMEOUT_EN
module dsp_gather_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next count: advance while idle, park at the terminal value, drop to zero otherwise.
    always_comb begin
        count_nxt_s = count_r;
        if (run) begin
            if (count_r == LAST_CNT) begin
                count_nxt_s = count_r;
            end else begin
                count_nxt_s = count_r + CNT_W'(1);
            end
        end else begin
            count_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Idle count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign expired = (count_r == LAST_CNT);

endmodule
`endif

// File: rtl/dsp_lane_gather.sv
// dsp_lane_gather: packs scalar (a,b) operand pairs from a valid/ready stream into
// LANES-wide vectors for the SIMD DSP adders/subtractors, with a lane-valid mask.
// A bundle closes when its last lane fills or on in_last; unused lanes read as zero.
// While a bundle is held, a new pair may enter lane 0 of the next bundle in the same
// cycle the held one is taken, so the stream sustains one pair per cycle.
// Optional feature macro: GATHER_TIMEOUT_EN -- when defined, a partial bundle that sees
// no new pair for TIMEOUT cycles is closed as if in_last had arrived.
module dsp_lane_gather
    import dsp_gather_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*LANES-1:0] out_a,
    output logic [WIDTH*LANES-1:0] out_b,
    output logic [LANES-1:0]       out_mask
);

    localparam int DATA_W = WIDTH * LANES;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic SINGLE_LANE = (LANES == 1);

    // Reject configurations that do not fit one DSP operand.
    generate
        if ((LANES < 1) || (LANES > 4) || (LANES > max_lanes(WIDTH))) begin : g_bad_lanes
            $fatal(1, "dsp_lane_gather: LANES=%0d does not fit WIDTH=%0d", LANES, WIDTH);
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $fatal(1, "dsp_lane_gather: TIMEOUT must be at least 1");
        end
    endgenerate

    gather_state_t     state_r;
    gather_state_t     state_nxt_s;
    logic [IDX_W-1:0]  lane_idx_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [LANES-1:0]  mask_r;
    logic [DATA_W-1:0] a_nxt_s;
    logic [DATA_W-1:0] b_nxt_s;
    logic [LANES-1:0]  mask_nxt_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              accept_s;
    logic              fill_close_s;
    logic              refill_close_s;
    logic              timeout_s;

    assign accept_s       = in_valid & in_ready_s;
    // Closing condition while filling: last lane reached or explicit end of group.
    assign fill_close_s   = in_last | (lane_idx_r == LAST_IDX);
    // Closing condition for a pair that starts a fresh bundle during hand-off.
    assign refill_close_s = in_last | SINGLE_LANE;

`ifdef GATHER_TIMEOUT_EN
    logic run_s;
    logic expired_s;

    // The idle counter only runs for a partial bundle that received nothing this cycle.
    assign run_s = (state_r == FILL) & (lane_idx_r != {IDX_W{1'b0}}) & ~accept_s;

    dsp_gather_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run_s),
        .expired (expired_s)
    );

    assign timeout_s = run_s & expired_s;
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    state_nxt_s = fill_close_s ? HOLD : FILL;
                end else if (timeout_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = (accept_s && refill_close_s) ? HOLD : FILL;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // FSM outputs: input is open while filling, or in HOLD only when the bundle is taken.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            FILL: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            HOLD: begin
                in_ready_s  = out_ready;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Lane storage next values: write the current lane, or restart a bundle on hand-off.
    always_comb begin
        a_nxt_s    = a_r;
        b_nxt_s    = b_r;
        mask_nxt_s = mask_r;
        idx_nxt_s  = lane_idx_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    for (int i = 0; i < LANES; i++) begin
                        a_nxt_s[i*WIDTH +: WIDTH] = (lane_idx_r == IDX_W'(i)) ? in_a : a_r[i*WIDTH +: WIDTH];
                        b_nxt_s[i*WIDTH +: WIDTH] = (lane_idx_r == IDX_W'(i)) ? in_b : b_r[i*WIDTH +: WIDTH];
                        mask_nxt_s[i]             = (lane_idx_r == IDX_W'(i)) ? 1'b1 : mask_r[i];
                    end
                    idx_nxt_s = fill_close_s ? {IDX_W{1'b0}} : (lane_idx_r + IDX_W'(1));
                end else if (timeout_s) begin
                    idx_nxt_s = {IDX_W{1'b0}};
                end else begin
                    idx_nxt_s = lane_idx_r;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    a_nxt_s    = {DATA_W{1'b0}};
                    b_nxt_s    = {DATA_W{1'b0}};
                    mask_nxt_s = {LANES{1'b0}};
                    idx_nxt_s  = {IDX_W{1'b0}};
                    if (accept_s) begin
                        a_nxt_s[WIDTH-1:0] = in_a;
                        b_nxt_s[WIDTH-1:0] = in_b;
                        mask_nxt_s[0]      = 1'b1;
                        idx_nxt_s          = refill_close_s ? {IDX_W{1'b0}} : IDX_W'(1);
                    end else begin
                        idx_nxt_s = {IDX_W{1'b0}};
                    end
                end else begin
                    idx_nxt_s = lane_idx_r;
                end
            end
            default: begin
                a_nxt_s    = {DATA_W{1'b0}};
                b_nxt_s    = {DATA_W{1'b0}};
                mask_nxt_s = {LANES{1'b0}};
                idx_nxt_s  = {IDX_W{1'b0}};
            end
        endcase
    end

    // Lane storage, mask and lane pointer registers; reset discards any partial bundle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            mask_r     <= {LANES{1'b0}};
            lane_idx_r <= {IDX_W{1'b0}};
        end else begin
            a_r        <= a_nxt_s;
            b_r        <= b_nxt_s;
            mask_r     <= mask_nxt_s;
            lane_idx_r <= idx_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_a     = a_r;
    assign out_b     = b_r;
    assign out_mask  = mask_r;

endmodule

// File: tb/tb_dsp_lane_gather.sv
// Self-checking bench for dsp_lane_gather (WIDTH=12, LANES=4, TIMEOUT=16).
// Directed vector table, hand-written multi-cycle sequences and a randomized run
// compared against a queue-based bundle model.
module tb_dsp_lane_gather;

    localparam int W  = 12;
    localparam int L  = 4;
    localparam int TO = 16;
    localparam int DW = W * L;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [L-1:0]  out_mask;

    int n_cmp;
    int n_err;

    dsp_lane_gather #(
        .WIDTH   (W),
        .LANES   (L),
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_mask  (out_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          v;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          last;
        logic          rdy;
        logic          exp_ir;
        logic          exp_ov;
        logic [L-1:0]  exp_m;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t tbl [10];

    // Reference model state: pairs of the open bundle plus the bundle on offer.
    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    bit            m_hold;
    logic [DW-1:0] m_ha;
    logic [DW-1:0] m_hb;
    logic [L-1:0]  m_hm;
`ifdef GATHER_TIMEOUT_EN
    int            m_idle;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic put(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic last, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        out_ready = rdy;
        #2;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #7;
        reset_n   = 1'b1;
        adv();
    endtask

    // Close the model's open bundle: pairs fill lanes from 0 upward, the rest stay zero.
    task automatic model_close();
        m_ha = '0;
        m_hb = '0;
        m_hm = '0;
        for (int i = 0; i < qa.size(); i++) begin
            m_ha[i*W +: W] = qa[i];
            m_hb[i*W +: W] = qb[i];
            m_hm[i]        = 1'b1;
        end
        qa.delete();
        qb.delete();
        m_hold = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] cap_a;
        logic [DW-1:0] cap_b;
        logic [DW-1:0] pk_a;
        logic [DW-1:0] pk_b;
        logic [W-1:0]  px_a;
        logic [W-1:0]  px_b;
        logic          v;
        logic          r;
        logic          last;
        logic          acc;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        int            stalls;
        int            ov_seen;
        int            pos[$];
        int            sum;
        int            exp_sum [4];

        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        cap_a    = '0;
        cap_b    = '0;

        //                v     a        b        last  rdy   ir    ov    mask     out_a                 out_b
        tbl[0] = '{1'b1, 12'hFFF, 12'h010, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[1] = '{1'b1, 12'h017, 12'h007, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[2] = '{1'b1, 12'h0FF, 12'h007, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[3] = '{1'b1, 12'hFEC, 12'hFF9, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[4] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 48'hFEC_0FF_017_FFF, 48'hFF9_007_007_010};
        tbl[5] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[6] = '{1'b1, 12'h001, 12'hFF0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[7] = '{1'b1, 12'hFE9, 12'hFF9, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};
        tbl[8] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 48'h000_000_FE9_001, 48'h000_000_FF9_FF0};
        tbl[9] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 48'h0,               48'h0};

        exp_sum[0] = 15;
        exp_sum[1] = 30;
        exp_sum[2] = 262;
        exp_sum[3] = -27;

        // Reset state
        do_reset();
        put(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_mask", out_mask, 4'b0000);
        check("rst_out_a", out_a, 48'h0);
        check("rst_in_ready", in_ready, 1'b1);
        adv();

        // Full and short bundles from the vector table
        for (int i = 0; i < 10; i++) begin
            put(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].rdy);
            check("tbl_in_ready", in_ready, tbl[i].exp_ir);
            check("tbl_out_valid", out_valid, tbl[i].exp_ov);
            if (tbl[i].exp_ov) begin
                check("tbl_out_mask", out_mask, tbl[i].exp_m);
                check("tbl_out_a", out_a, tbl[i].exp_a);
                check("tbl_out_b", out_b, tbl[i].exp_b);
            end
            if (i == 4) begin
                cap_a = out_a;
                cap_b = out_b;
            end
            adv();
        end

        // Lane-wise sums as the downstream 4-lane adder would produce them
        for (int i = 0; i < 4; i++) begin
            sum = $signed(cap_a[i*W +: W]) + $signed(cap_b[i*W +: W]);
            check("add_v4_lane", sum, exp_sum[i]);
        end

        // Reset mid-bundle discards the partial bundle
        do_reset();
        put(1'b1, 12'h111, 12'h222, 1'b0, 1'b1);
        adv();
        put(1'b1, 12'h333, 12'h444, 1'b0, 1'b1);
        adv();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_mask", out_mask, 4'b0000);
        #4;
        reset_n = 1'b1;
        adv();
        for (int i = 0; i < 4; i++) begin
            put(1'b1, W'(i + 5), W'(i + 9), 1'b0, 1'b1);
            pk_a[i*W +: W] = W'(i + 5);
            pk_b[i*W +: W] = W'(i + 9);
            adv();
        end
        put(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        check("postrst_out_valid", out_valid, 1'b1);
        check("postrst_out_mask", out_mask, 4'b1111);
        check("postrst_out_a", out_a, pk_a);
        check("postrst_out_b", out_b, pk_b);
        adv();

        // Backpressure: held bundle stays put, input stalls, then hand-off without a bubble
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(1'b1, W'(12'h100 + i), W'(12'h200 + i), 1'b0, 1'b1);
            pk_a[i*W +: W] = W'(12'h100 + i);
            pk_b[i*W +: W] = W'(12'h200 + i);
            adv();
        end
        px_a = 12'hABC;
        px_b = 12'h876;
        for (int k = 0; k < 5; k++) begin
            put(1'b1, px_a, px_b, 1'b0, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_a", out_a, pk_a);
            check("bp_out_b", out_b, pk_b);
            check("bp_out_mask", out_mask, 4'b1111);
            adv();
        end
        put(1'b1, px_a, px_b, 1'b0, 1'b1);
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b1);
        adv();
        pk_a = '0;
        pk_b = '0;
        pk_a[W-1:0] = px_a;
        pk_b[W-1:0] = px_b;
        for (int i = 1; i < 4; i++) begin
            put(1'b1, W'(12'h300 + i), W'(12'h400 + i), 1'b0, 1'b1);
            if (i == 1) begin
                check("bp_refill_out_valid", out_valid, 1'b0);
            end
            pk_a[i*W +: W] = W'(12'h300 + i);
            pk_b[i*W +: W] = W'(12'h400 + i);
            adv();
        end
        put(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        check("bp_next_out_valid", out_valid, 1'b1);
        check("bp_next_out_a", out_a, pk_a);
        check("bp_next_out_b", out_b, pk_b);
        check("bp_next_out_mask", out_mask, 4'b1111);
        adv();

        // Streaming: 12 back-to-back pairs give 3 bundles spaced 4 cycles apart
        do_reset();
        stalls = 0;
        pos.delete();
        for (int c = 0; c < 16; c++) begin
            put((c < 12), W'(c + 1), W'(c + 7), 1'b0, 1'b1);
            if ((c < 12) && !in_ready) stalls++;
            if (out_valid) pos.push_back(c);
            adv();
        end
        check("stream_stalls", stalls, 0);
        check("stream_bundles", pos.size(), 3);
        if (pos.size() == 3) begin
            check("stream_first_pos", pos[0], 4);
            check("stream_gap1", pos[1] - pos[0], 4);
            check("stream_gap2", pos[2] - pos[1], 4);
        end

        // Idle partial bundle: auto-flush when the timeout feature is built in, else it waits
        do_reset();
        put(1'b1, 12'h5A5, 12'h0C3, 1'b0, 1'b1);
        adv();
`ifdef GATHER_TIMEOUT_EN
        ov_seen = 0;
        for (int k = 1; k < 17; k++) begin
            put(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
            if (out_valid) ov_seen++;
            adv();
        end
        check("timeout_early", ov_seen, 0);
        put(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        check("timeout_out_valid", out_valid, 1'b1);
        check("timeout_out_mask", out_mask, 4'b0001);
        check("timeout_out_a", out_a, 48'h000_000_000_5A5);
        adv();
`else
        ov_seen = 0;
        for (int k = 0; k < 100; k++) begin
            put(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
            if (out_valid) ov_seen++;
            adv();
        end
        check("no_timeout_out_valid", ov_seen, 0);
        put(1'b1, 12'h00F, 12'h0F0, 1'b1, 1'b1);
        adv();
        put(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        check("late_last_out_valid", out_valid, 1'b1);
        check("late_last_out_mask", out_mask, 4'b0011);
        check("late_last_out_a", out_a, 48'h000_000_00F_5A5);
        adv();
`endif

        // Randomized traffic against the bundle model
        do_reset();
        qa.delete();
        qb.delete();
        m_hold = 1'b0;
        m_ha = '0;
        m_hb = '0;
        m_hm = '0;
`ifdef GATHER_TIMEOUT_EN
        m_idle = 0;
`endif
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 9) < 7);
            r    = ($urandom_range(0, 9) < 7);
            last = ($urandom_range(0, 4) == 0);
            ra   = W'($urandom);
            rb   = W'($urandom);
            put(v, ra, rb, last, r);
            check("rnd_in_ready", in_ready, (!m_hold) || r);
            check("rnd_out_valid", out_valid, m_hold);
            if (m_hold) begin
                check("rnd_out_a", out_a, m_ha);
                check("rnd_out_b", out_b, m_hb);
                check("rnd_out_mask", out_mask, m_hm);
            end
            acc = v && ((!m_hold) || r);
            if (m_hold && r) m_hold = 1'b0;
            if (acc) begin
                qa.push_back(ra);
                qb.push_back(rb);
`ifdef GATHER_TIMEOUT_EN
                m_idle = 0;
`endif
                if ((qa.size() == L) || last) model_close();
            end else begin
`ifdef GATHER_TIMEOUT_EN
                if (!m_hold && (qa.size() > 0)) begin
                    if (m_idle == TO - 1) begin
                        model_close();
                        m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end else begin
                    m_idle = 0;
                end
`endif
            end
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
